rc4_stream_core: RTL and testbench

// - Parametrised RC4 cipher engine: byte-serial key load, KSA, optional keystream discard (RC4-drop[N]), then streaming XOR.
// - Encryption and decryption are the same operation. Sits between a key source and a byte data path.
// - All three interfaces are valid/ready. Supports variable key length and mid-stream rekey.

---
 rtl/rc4_stream_core.sv | 277 +++++++++++++++++++++++++++
 tb/tb_rc4_stream_core.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_stream_core.sv
// rc4_stream_core
// RC4 cipher engine. A key is loaded one byte at a time, the key-scheduling
// pass runs one iteration per cycle, an optional number of keystream bytes is
// thrown away (RC4-drop[N]), and then every accepted data byte is XORed with
// one keystream byte. Encryption and decryption are the same operation.
//
// Ports
//   clk, rst                 single clock, asynchronous active-high reset
//   key_in/key_rvalid/
//   key_last/key_rready      byte-serial key input; key_last marks the final byte
//   rekey                    one-cycle pulse: drop the stream and reload a key
//   data_in/data_rvalid/
//   data_rready              plaintext/ciphertext input
//   data_out/data_wvalid/
//   data_wready              data_in XOR keystream, one cycle after acceptance
//   ks_ready                 high while the core is streaming
//
// Parameters
//   KEY_BYTES  maximum key length (1..256)
//   DROP_N     keystream bytes discarded before the first data byte (0..4095)

module rc4_stream_core #(
  parameter int KEY_BYTES = 16,
  parameter int DROP_N    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  input  logic       key_rvalid,
  input  logic       key_last,
  output logic       key_rready,
  input  logic       rekey,
  input  logic [7:0] data_in,
  input  logic       data_rvalid,
  output logic       data_rready,
  output logic [7:0] data_out,
  output logic       data_wvalid,
  input  logic       data_wready,
  output logic       ks_ready
);

  localparam int LEN_W  = $clog2(KEY_BYTES + 1);
  // Key buffer index width; a one-byte key still gets a 1-bit index.
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int KBUF_N = 1 << KIDX_W;
  localparam bit HAS_DROP = (DROP_N > 0);
  localparam logic [11:0] DROP_LAST = HAS_DROP ? 12'(DROP_N - 1) : 12'd0;
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_LOAD,
    ST_KSA,
    ST_DROP,
    ST_STREAM
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [KIDX_W-1:0] kidx_q, kidx_d;
  logic [11:0]       drop_cnt_q, drop_cnt_d;
  logic              key_rready_q, key_rready_d;
  logic              ks_ready_q, ks_ready_d;
  logic              data_wvalid_q, data_wvalid_d;
  logic [7:0]        data_out_q, data_out_d;

  // Permutation state and key buffer; neither needs a reset because INIT
  // rebuilds S and LOAD overwrites every key byte that KSA will read.
  logic [7:0] s_q [256];
  logic [7:0] k_q [KBUF_N];

  logic       s_fill;
  logic       swap_en;
  logic [7:0] swap_a;
  logic [7:0] swap_b;
  logic       k_we;

  logic             key_accept;
  logic             data_accept;
  logic [LEN_W-1:0] kidx_inc;
  logic             kidx_wrap;

  logic [7:0] ksa_j;
  logic [7:0] prga_i;
  logic [7:0] prga_si;
  logic [7:0] prga_j;
  logic [7:0] prga_sj;
  logic [7:0] prga_t;
  logic [7:0] prga_ks;

  // A rekey pulse withdraws both ready signals in the same cycle so that no
  // upstream source believes a byte was taken when it was not.
  assign key_rready  = key_rready_q && !rekey;
  assign data_rready = ks_ready_q && !rekey && (!data_wvalid_q || data_wready);
  assign data_out    = data_out_q;
  assign data_wvalid = data_wvalid_q;
  assign ks_ready    = ks_ready_q;

  assign key_accept  = key_rvalid && key_rready;
  assign data_accept = data_rvalid && data_rready;

  // Cycling key index replaces i mod len.
  assign kidx_inc  = LEN_W'(kidx_q) + LEN_W'(1);
  assign kidx_wrap = (kidx_inc == len_q);

  assign ksa_j = j_q + s_q[i_q] + k_q[kidx_q];

  assign prga_i  = i_q + 8'd1;
  assign prga_si = s_q[prga_i];
  assign prga_j  = j_q + prga_si;
  assign prga_sj = s_q[prga_j];
  assign prga_t  = prga_si + prga_sj;

  // The lookup must see the permutation after the swap. Reading S before the
  // swap lands, the two swapped slots are patched in by hand; when i'==j'
  // both patches give the same byte.
  always_comb begin
    if (prga_t == prga_i) begin
      prga_ks = prga_sj;
    end else if (prga_t == prga_j) begin
      prga_ks = prga_si;
    end else begin
      prga_ks = s_q[prga_t];
    end
  end

  // Next-state logic: one KSA iteration or one PRGA step per cycle, with a
  // rekey pulse overriding everything outside INIT.
  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    len_d         = len_q;
    kidx_d        = kidx_q;
    drop_cnt_d    = drop_cnt_q;
    key_rready_d  = key_rready_q;
    ks_ready_d    = ks_ready_q;
    data_wvalid_d = data_wvalid_q;
    data_out_d    = data_out_q;
    s_fill        = 1'b0;
    swap_en       = 1'b0;
    swap_a        = prga_i;
    swap_b        = prga_j;
    k_we          = 1'b0;

    if (rekey && (state_q != ST_INIT)) begin
      state_d       = ST_INIT;
      len_d         = '0;
      key_rready_d  = 1'b0;
      ks_ready_d    = 1'b0;
      data_wvalid_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          s_fill       = 1'b1;
          i_d          = 8'd0;
          j_d          = 8'd0;
          kidx_d       = '0;
          len_d        = '0;
          key_rready_d = 1'b1;
          state_d      = ST_LOAD;
        end

        ST_LOAD: begin
          if (key_accept) begin
            k_we  = 1'b1;
            len_d = len_q + LEN_W'(1);
            // A full buffer ends the load whether or not key_last is set.
            if (key_last || (len_q == LEN_FULL)) begin
              key_rready_d = 1'b0;
              i_d          = 8'd0;
              j_d          = 8'd0;
              kidx_d       = '0;
              state_d      = ST_KSA;
            end
          end
        end

        ST_KSA: begin
          swap_en = 1'b1;
          swap_a  = i_q;
          swap_b  = ksa_j;
          i_d     = i_q + 8'd1;
          j_d     = ksa_j;
          kidx_d  = kidx_wrap ? '0 : kidx_q + KIDX_W'(1);
          if (i_q == 8'hFF) begin
            j_d        = 8'd0;
            drop_cnt_d = 12'd0;
            if (HAS_DROP) begin
              state_d = ST_DROP;
            end else begin
              ks_ready_d = 1'b1;
              state_d    = ST_STREAM;
            end
          end
        end

        ST_DROP: begin
          swap_en    = 1'b1;
          i_d        = prga_i;
          j_d        = prga_j;
          drop_cnt_d = drop_cnt_q + 12'd1;
          if (drop_cnt_q == DROP_LAST) begin
            ks_ready_d = 1'b1;
            state_d    = ST_STREAM;
          end
        end

        ST_STREAM: begin
          if (data_accept) begin
            swap_en       = 1'b1;
            i_d           = prga_i;
            j_d           = prga_j;
            data_out_d    = data_in ^ prga_ks;
            data_wvalid_d = 1'b1;
          end else if (data_wvalid_q && data_wready) begin
            data_wvalid_d = 1'b0;
          end
        end

        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      i_q           <= 8'd0;
      j_q           <= 8'd0;
      len_q         <= '0;
      kidx_q        <= '0;
      drop_cnt_q    <= 12'd0;
      key_rready_q  <= 1'b0;
      ks_ready_q    <= 1'b0;
      data_wvalid_q <= 1'b0;
      data_out_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      len_q         <= len_d;
      kidx_q        <= kidx_d;
      drop_cnt_q    <= drop_cnt_d;
      key_rready_q  <= key_rready_d;
      ks_ready_q    <= ks_ready_d;
      data_wvalid_q <= data_wvalid_d;
      data_out_q    <= data_out_d;
    end
  end

  // Permutation array: identity fill in INIT, otherwise at most one swap per
  // cycle. Equal swap addresses write the same byte twice, which is harmless.
  always_ff @(posedge clk) begin
    if (s_fill) begin
      for (int n = 0; n < 256; n++) begin
        s_q[n] <= 8'(n);
      end
    end else if (swap_en) begin
      s_q[swap_a] <= s_q[swap_b];
      s_q[swap_b] <= s_q[swap_a];
    end
  end

  // Key buffer, written at the current key length.
  always_ff @(posedge clk) begin
    if (k_we) begin
      k_q[len_q[KIDX_W-1:0]] <= key_in;
    end
  end

endmodule

// File: tb/tb_rc4_stream_core.sv
// tb_rc4_stream_core
// Three instances: default (16-byte key, no drop), DROP_N=1, and KEY_BYTES=3.
// Expected bytes come from a textbook RC4 model kept here plus the published
// test vectors.

module tb_rc4_stream_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst         [3];
  logic [7:0] key_in      [3];
  logic       key_rvalid  [3];
  logic       key_last    [3];
  logic       key_rready  [3];
  logic       rekey       [3];
  logic [7:0] data_in     [3];
  logic       data_rvalid [3];
  logic       data_rready [3];
  logic [7:0] data_out    [3];
  logic       data_wvalid [3];
  logic       data_wready [3];
  logic       ks_ready    [3];

  rc4_stream_core #(.KEY_BYTES(16), .DROP_N(0)) dut0 (
    .clk(clk), .rst(rst[0]), .key_in(key_in[0]), .key_rvalid(key_rvalid[0]),
    .key_last(key_last[0]), .key_rready(key_rready[0]), .rekey(rekey[0]),
    .data_in(data_in[0]), .data_rvalid(data_rvalid[0]), .data_rready(data_rready[0]),
    .data_out(data_out[0]), .data_wvalid(data_wvalid[0]), .data_wready(data_wready[0]),
    .ks_ready(ks_ready[0])
  );

  rc4_stream_core #(.KEY_BYTES(16), .DROP_N(1)) dut1 (
    .clk(clk), .rst(rst[1]), .key_in(key_in[1]), .key_rvalid(key_rvalid[1]),
    .key_last(key_last[1]), .key_rready(key_rready[1]), .rekey(rekey[1]),
    .data_in(data_in[1]), .data_rvalid(data_rvalid[1]), .data_rready(data_rready[1]),
    .data_out(data_out[1]), .data_wvalid(data_wvalid[1]), .data_wready(data_wready[1]),
    .ks_ready(ks_ready[1])
  );

  rc4_stream_core #(.KEY_BYTES(3), .DROP_N(0)) dut2 (
    .clk(clk), .rst(rst[2]), .key_in(key_in[2]), .key_rvalid(key_rvalid[2]),
    .key_last(key_last[2]), .key_rready(key_rready[2]), .rekey(rekey[2]),
    .data_in(data_in[2]), .data_rvalid(data_rvalid[2]), .data_rready(data_rready[2]),
    .data_out(data_out[2]), .data_wvalid(data_wvalid[2]), .data_wready(data_wready[2]),
    .ks_ready(ks_ready[2])
  );

  int checks   = 0;
  int failures = 0;

  int kmax  [3] = '{16, 16, 3};
  int dropn [3] = '{0, 1, 0};

  // Reference RC4 state, one copy per instance.
  int m_s [3][256];
  int m_i [3];
  int m_j [3];

  logic [7:0] cur_key  [$];
  logic [7:0] cur_data [$];
  logic [7:0] rx       [$];
  logic [7:0] expq     [$];
  logic [7:0] want     [$];
  int         last_cycles;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Textbook PRGA: swap, then look up S[S[i]+S[j]] in the updated table.
  function automatic int modelNext(input int k);
    int tmp;
    m_i[k] = (m_i[k] + 1) % 256;
    m_j[k] = (m_j[k] + m_s[k][m_i[k]]) % 256;
    tmp = m_s[k][m_i[k]];
    m_s[k][m_i[k]] = m_s[k][m_j[k]];
    m_s[k][m_j[k]] = tmp;
    return m_s[k][(m_s[k][m_i[k]] + m_s[k][m_j[k]]) % 256];
  endfunction

  // Textbook KSA over the key truncated to the instance's capacity, then
  // burn the configured number of keystream bytes.
  task automatic modelKey(input int k);
    int len, j, tmp;
    len = (cur_key.size() < kmax[k]) ? cur_key.size() : kmax[k];
    for (int n = 0; n < 256; n++) m_s[k][n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + m_s[k][n] + int'(cur_key[n % len])) % 256;
      tmp = m_s[k][n];
      m_s[k][n] = m_s[k][j];
      m_s[k][j] = tmp;
    end
    m_i[k] = 0;
    m_j[k] = 0;
    for (int d = 0; d < dropn[k]; d++) void'(modelNext(k));
  endtask

  task automatic setKey(input string s);
    cur_key.delete();
    for (int n = 0; n < s.len(); n++) cur_key.push_back(s[n]);
  endtask

  task automatic setData(input string s);
    cur_data.delete();
    for (int n = 0; n < s.len(); n++) cur_data.push_back(s[n]);
  endtask

  task automatic loadKey(input int k, input bit use_last);
    int t;
    for (int b = 0; b < cur_key.size(); b++) begin
      t = 0;
      @(negedge clk);
      key_in[k]     = cur_key[b];
      key_rvalid[k] = 1'b1;
      key_last[k]   = use_last && (b == cur_key.size() - 1);
      #1;
      while (!key_rready[k] && t < 600) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (t >= 600) checkOutput("key_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      key_rvalid[k] = 1'b0;
      key_last[k]   = 1'b0;
    end
  endtask

  // Counts rising edges after the last key byte until ks_ready is seen.
  task automatic waitReady(input int k, input int expected);
    int c;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!ks_ready[k] && c < 1000);
    checkOutput("ks_latency", c, expected);
  endtask

  task automatic doRekey(input int k);
    @(negedge clk);
    rekey[k] = 1'b1;
    @(posedge clk);
    #1;
    rekey[k] = 1'b0;
  endtask

  // Streams cur_data through instance k. mode 0: sink always ready,
  // mode 1: sink ready 1010..., mode 2: random sink. gaps adds random
  // source bubbles. Collects outputs in rx and model bytes in expq.
  task automatic applyStimulus(input int k, input int mode, input bit gaps);
    int n, sent, cycles;
    bit in_fire, out_fire, stall_prev;
    logic [7:0] held;
    n = cur_data.size();
    sent = 0;
    cycles = 0;
    stall_prev = 1'b0;
    held = 8'h00;
    rx.delete();
    expq.delete();
    while (rx.size() < n && cycles < 40 * n + 100) begin
      @(negedge clk);
      cycles++;
      case (mode)
        0:       data_wready[k] = 1'b1;
        1:       data_wready[k] = cycles[0];
        default: data_wready[k] = 1'($urandom_range(0, 1));
      endcase
      if (sent < n && (!gaps || $urandom_range(0, 3) != 0)) begin
        data_rvalid[k] = 1'b1;
        data_in[k]     = cur_data[sent];
      end else begin
        data_rvalid[k] = 1'b0;
        data_in[k]     = 8'($urandom);
      end
      #1;
      if (stall_prev) begin
        checkOutput("hold_valid", 32'(data_wvalid[k]), 32'd1);
        checkOutput("hold_data", 32'(data_out[k]), 32'(held));
      end
      in_fire    = data_rvalid[k] && data_rready[k];
      out_fire   = data_wvalid[k] && data_wready[k];
      stall_prev = data_wvalid[k] && !data_wready[k];
      held       = data_out[k];
      if (in_fire) begin
        expq.push_back(cur_data[sent] ^ 8'(modelNext(k)));
        sent++;
      end
      if (out_fire) rx.push_back(data_out[k]);
      @(posedge clk);
    end
    #1;
    data_rvalid[k] = 1'b0;
    data_wready[k] = 1'b1;
    last_cycles = cycles;
    checkOutput("rx_count", rx.size(), n);
    for (int q = 0; q < rx.size() && q < expq.size(); q++) begin
      checkOutput("model_byte", 32'(rx[q]), 32'(expq[q]));
    end
  endtask

  task automatic checkVector();
    checkOutput("vector_len", rx.size(), want.size());
    for (int q = 0; q < rx.size() && q < want.size(); q++) begin
      checkOutput("vector_byte", 32'(rx[q]), 32'(want[q]));
    end
  endtask

  task automatic checkResetValues(input int k);
    checkOutput("rst_key_rready", 32'(key_rready[k]), 32'd0);
    checkOutput("rst_data_rready", 32'(data_rready[k]), 32'd0);
    checkOutput("rst_data_wvalid", 32'(data_wvalid[k]), 32'd0);
    checkOutput("rst_data_out", 32'(data_out[k]), 32'd0);
    checkOutput("rst_ks_ready", 32'(ks_ready[k]), 32'd0);
  endtask

  task automatic randomRound(input int k, input int exp_lat);
    int klen, dlen;
    doRekey(k);
    cur_key.delete();
    klen = $urandom_range(1, kmax[k]);
    for (int n = 0; n < klen; n++) cur_key.push_back(8'($urandom));
    loadKey(k, 1'b1);
    waitReady(k, exp_lat);
    modelKey(k);
    cur_data.delete();
    dlen = $urandom_range(16, 40);
    for (int n = 0; n < dlen; n++) cur_data.push_back(8'($urandom));
    applyStimulus(k, 2, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k]         = 1'b1;
      key_in[k]      = 8'h00;
      key_rvalid[k]  = 1'b0;
      key_last[k]    = 1'b0;
      rekey[k]       = 1'b0;
      data_in[k]     = 8'h00;
      data_rvalid[k] = 1'b0;
      data_wready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) checkResetValues(k);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) checkOutput("load_after_init", 32'(key_rready[k]), 32'd1);

    // "Key" / "Plaintext" at full rate
    setKey("Key");
    loadKey(0, 1'b1);
    waitReady(0, 256);
    modelKey(0);
    setData("Plaintext");
    applyStimulus(0, 0, 1'b0);
    checkOutput("throughput_short", last_cycles, 10);
    want = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    checkVector();

    // Rekey while an output byte is stuck behind a stalled sink
    @(negedge clk);
    data_wready[0] = 1'b0;
    data_rvalid[0] = 1'b1;
    data_in[0]     = 8'h55;
    #1;
    checkOutput("rready_before_pending", 32'(data_rready[0]), 32'd1);
    @(posedge clk);
    #1;
    data_rvalid[0] = 1'b0;
    checkOutput("pending_wvalid", 32'(data_wvalid[0]), 32'd1);
    @(negedge clk);
    rekey[0] = 1'b1;
    data_rvalid[0] = 1'b1;
    #1;
    checkOutput("rready_during_rekey", 32'(data_rready[0]), 32'd0);
    @(posedge clk);
    #1;
    rekey[0] = 1'b0;
    data_rvalid[0] = 1'b0;
    checkOutput("rekey_wvalid", 32'(data_wvalid[0]), 32'd0);
    checkOutput("rekey_rready", 32'(data_rready[0]), 32'd0);
    checkOutput("rekey_ks_ready", 32'(ks_ready[0]), 32'd0);
    checkOutput("rekey_key_rready", 32'(key_rready[0]), 32'd0);
    data_wready[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rekey_reload", 32'(key_rready[0]), 32'd1);
    setKey("Wiki");
    loadKey(0, 1'b1);
    waitReady(0, 256);
    modelKey(0);
    setData("pedia");
    applyStimulus(0, 0, 1'b0);
    want = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    checkVector();

    // "Secret" / "Attack at dawn" with the sink toggling every cycle
    doRekey(0);
    setKey("Secret");
    loadKey(0, 1'b1);
    waitReady(0, 256);
    modelKey(0);
    setData("Attack at dawn");
    applyStimulus(0, 1, 1'b0);
    want = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B, 8'h38,
             8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};
    checkVector();

    // Random keys, data, bubbles and backpressure
    for (int r = 0; r < 4; r++) randomRound(0, 256);

    // Long run across the i wrap at full rate on the same key
    cur_data.delete();
    for (int n = 0; n < 300; n++) cur_data.push_back(8'($urandom));
    applyStimulus(0, 0, 1'b0);
    checkOutput("throughput_long", last_cycles, 301);

    // DROP_N = 1
    setKey("Key");
    loadKey(1, 1'b1);
    waitReady(1, 257);
    modelKey(1);
    cur_data.delete();
    for (int n = 0; n < 3; n++) cur_data.push_back(8'h00);
    applyStimulus(1, 0, 1'b0);
    want = '{8'h9F, 8'h77, 8'h81};
    checkVector();
    for (int r = 0; r < 2; r++) randomRound(1, 257);

    // KEY_BYTES = 3: load ends on the third byte, a fourth byte stalls
    setKey("Key");
    loadKey(2, 1'b0);
    @(negedge clk);
    key_in[2]     = 8'hA5;
    key_rvalid[2] = 1'b1;
    #1;
    checkOutput("full_key_stall", 32'(key_rready[2]), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("full_key_stall_2", 32'(key_rready[2]), 32'd0);
    key_rvalid[2] = 1'b0;
    waitReady(2, 255);
    modelKey(2);
    setData("Plaintext");
    applyStimulus(2, 2, 1'b1);
    want = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    checkVector();

    // Asynchronous reset in the middle of KSA
    doRekey(0);
    cur_key.delete();
    for (int n = 0; n < 8; n++) cur_key.push_back(8'($urandom));
    loadKey(0, 1'b1);
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    checkResetValues(0);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    setKey("Key");
    loadKey(0, 1'b1);
    waitReady(0, 256);
    modelKey(0);
    setData("Plaintext");
    applyStimulus(0, 0, 1'b0);
    want = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    checkVector();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
